// File: rtl/inst_queue_pkg.sv
// Shared constants and helpers for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    // Default geometry: 4 entries, 64-bit register bus pc, 32-bit instruction bus.
    localparam int INST_Q_DEPTH = 4;
    localparam int REG_BUS_W    = 64;
    localparam int INST_BUS_W   = 32;

    // Reset pc of the core, kept here so the fetch side and the queue agree.
    localparam logic [REG_BUS_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    // Queue activity decided for the current cycle; flush overrides everything.
    typedef enum logic [2:0] {
        Q_IDLE,
        Q_PUSH,
        Q_POP,
        Q_PUSH_POP,
        Q_FLUSH
    } q_op_e;

    // An instruction fetch address is misaligned when it is not word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return |pc_lo;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Storage array for the instruction queue: one write port, one asynchronous read port.
module inst_queue_ram #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 97,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the accepted entry into its slot.
    // NOTE: no reset on the array; validity is tracked by the pointers and count, so stale data is never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: in-order FIFO of (pc, inst, misalign)
// with flush on redirect and handshakes that never see out_ready combinationally.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INST_Q_DEPTH,
    parameter int PC_W   = REG_BUS_W,
    parameter int INST_W = INST_BUS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_inst,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    output logic                   out_misalign,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = 1 + PC_W + INST_W;

    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    q_op_e              op;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Handshakes depend only on registered occupancy and flush.
    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Classify this cycle's activity; flush wins over push and pop.
    // NOTE: op gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        op = Q_IDLE;
        if (flush) begin
            op = Q_FLUSH;
        end else if (push && pop) begin
            op = Q_PUSH_POP;
        end else if (push) begin
            op = Q_PUSH;
        end else if (pop) begin
            op = Q_POP;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            case (op)
                Q_FLUSH: begin
                    rd_ptr  <= '0;
                    wr_ptr  <= '0;
                    count_q <= '0;
                end
                Q_PUSH: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    count_q <= count_q + 1'b1;
                end
                Q_POP: begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    count_q <= count_q - 1'b1;
                end
                Q_PUSH_POP: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_entry = {pc_misaligned(in_pc[1:0]), in_pc, in_inst};

    inst_queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Present the head entry to decode, forced to zero whenever it is not valid.
    always_comb begin
        out_pc       = '0;
        out_inst     = '0;
        out_misalign = 1'b0;
        if (out_valid) begin
            out_inst     = head[INST_W-1:0];
            out_pc       = head[INST_W +: PC_W];
            out_misalign = head[ENTRY_W-1];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int VEC_W = 1 + 1 + 3 + 64 + 32 + 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t mq[$];

    logic [VEC_W-1:0] obs;

    inst_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_misalign (out_misalign),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign obs = {out_valid, in_ready, count, out_pc, out_inst, out_misalign};

    // Expected outputs from the model queue and the currently driven flush.
    function automatic logic [VEC_W-1:0] exp_vec();
        logic        v;
        logic        r;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        m;
        v   = (mq.size() != 0) && !flush;
        r   = (mq.size() != DEPTH) && !flush;
        pc  = '0;
        ins = '0;
        m   = 1'b0;
        if (v) begin
            pc  = mq[0].pc;
            ins = mq[0].inst;
            m   = |mq[0].pc[1:1] | mq[0].pc[0];
        end
        return {v, r, 3'(mq.size()), pc, ins, m};
    endfunction

    task automatic set(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                       input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = ins;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Advance one clock and apply the same transaction to the model.
    task automatic tick();
        logic do_pop;
        logic do_push;
        do_pop  = (mq.size() != 0) && !flush && out_ready;
        do_push = (mq.size() != DEPTH) && !flush && in_valid;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back('{in_pc, in_inst});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        set(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        set(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", obs, exp_vec());
        end
        rst = 1'b1;
        tick();
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
        end
        total++;
        if (in_ready !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got rdy=%b cnt=%0d v=%b want rdy=1 cnt=0 v=0",
                     in_ready, count, out_valid);
        end
        // Load three entries, then reset asynchronously in mid-cycle.
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        set(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL reset_preload: got cnt=%0d want 3", count);
        end
        #1;
        rst = 1'b0;
        #1;
        mq.delete();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 64'd0) begin
            bad++;
            $display("FAIL reset_async: got cnt=%0d v=%b pc=%h want cnt=0 v=0 pc=0",
                     count, out_valid, out_pc);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_fill_drain();
        logic [63:0] pcs  [4];
        logic [31:0] insts[4];
        pcs   = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
        insts = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        for (int i = 0; i < 4; i++) begin
            set(1'b1, pcs[i], insts[i], 1'b0, 1'b0);
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL fill_%0d: got %h want %h", i, obs, exp_vec());
            end
            tick();
        end
        set(1'b1, 64'h8000_0010, 32'h0040_0213, 1'b0, 1'b0);
        #1;
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b want cnt=4 rdy=0", count, in_ready);
        end
        tick();
        #1;
        total++;
        if (count !== 3'd4 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL fill_fifth: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            set(1'b0, '0, '0, 1'b0, 1'b1);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== insts[i]) begin
                bad++;
                $display("FAIL drain_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, pcs[i], insts[i]);
            end
            tick();
        end
        #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL drain_empty: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            set(1'b1, 64'h8000_1000 + 64'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stream_%0d: got %h want %h", i, obs, exp_vec());
            end
            if (i > 0) begin
                total++;
                if (count !== 3'd1 || out_valid !== 1'b1 ||
                    out_pc !== 64'h8000_1000 + 64'(4 * (i - 1))) begin
                    bad++;
                    $display("FAIL stream_flow_%0d: got cnt=%0d v=%b pc=%h want cnt=1 v=1 pc=%h",
                             i, count, out_valid, out_pc, 64'h8000_1000 + 64'(4 * (i - 1)));
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            set(1'b1, 64'h8000_2000 + 64'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        set(1'b1, 64'h8000_2010, 32'hB000_0004, 1'b0, 1'b1);
        #1;
        total++;
        if (in_ready !== 1'b0 || count !== 3'd4 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL full_pop_pre: got %h want %h", obs, exp_vec());
        end
        tick();
        #1;
        total++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 64'h8000_2004) begin
            bad++;
            $display("FAIL full_pop_after: got cnt=%0d rdy=%b pc=%h want cnt=3 rdy=1 pc=8000_2004",
                     count, in_ready, out_pc);
        end
        tick();
        #1;
        total++;
        if (count !== 3'd3 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL full_pop_both: got %h want %h", obs, exp_vec());
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 64'h8000_3000 + 64'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        set(1'b1, 64'h8000_300C, 32'hC000_0003, 1'b1, 1'b1);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== 64'd0) begin
            bad++;
            $display("FAIL flush_comb: got v=%b rdy=%b pc=%h want v=0 rdy=0 pc=0",
                     out_valid, in_ready, out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++;
            if (count !== 3'd0 || in_ready !== 1'b0 || obs !== exp_vec()) begin
                bad++;
                $display("FAIL flush_hold_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        set(1'b1, 64'h8000_0100, 32'h0000_0073, 1'b0, 1'b0);
        tick();
        set(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || count !== 3'd1) begin
            bad++;
            $display("FAIL flush_repush: got v=%b pc=%h cnt=%0d want v=1 pc=8000_0100 cnt=1",
                     out_valid, out_pc, count);
        end
        drain();
    endtask

    task automatic test_misalign();
        set(1'b1, 64'h8000_0002, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        set(1'b1, 64'h8000_0004, 32'h0000_0013, 1'b0, 1'b1);
        #1;
        total++;
        if (out_misalign !== 1'b1 || out_pc !== 64'h8000_0002) begin
            bad++;
            $display("FAIL misalign_set: got mis=%b pc=%h want mis=1 pc=8000_0002",
                     out_misalign, out_pc);
        end
        tick();
        set(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        total++;
        if (out_misalign !== 1'b0 || out_pc !== 64'h8000_0004) begin
            bad++;
            $display("FAIL misalign_clr: got mis=%b pc=%h want mis=0 pc=8000_0004",
                     out_misalign, out_pc);
        end
        drain();
    endtask

    task automatic test_random();
        logic        hold;
        logic [63:0] pc;
        logic [31:0] ins;
        hold = 1'b0;
        pc   = '0;
        ins  = '0;
        for (int i = 0; i < 800; i++) begin
            logic iv;
            logic fl;
            logic ordy;
            fl   = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            if (hold) begin
                iv = 1'b1;
            end else begin
                iv  = ($urandom_range(0, 9) < 7);
                pc  = {$urandom(), $urandom()};
                ins = $urandom();
            end
            set(iv, pc, ins, fl, ordy);
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
            // Keep a refused pair stable until accepted or flushed away.
            hold = iv && !fl && (mq.size() == DEPTH);
            tick();
        end
        drain();
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL random_end: got %h want %h", obs, exp_vec());
        end
    endtask

    initial begin
        rst = 1'b0;
        set(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer directly downstream of the fetch stage: captures (pc, instruction) pairs returned for each fetch address and presents them in order to decode.
- Decouples fetch from decode stalls with a small FIFO, and discards in-flight entries on a control-flow redirect (flush).
- Tags misaligned fetch addresses so decode can raise an instruction-address-misaligned exception.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_W, 64, pc width; matches the REG_BUS width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low; asserting it (rst=0) clears all state immediately.
- in_valid  input  1  fetch side presents a valid pc/inst pair.
- in_ready  output  1  queue accepts a pair this cycle.
- in_pc  input  PC_W  address of the fetched instruction.
- in_inst  input  INST_W  fetched instruction word.
- flush  input  1  redirect; discard all queued and incoming entries.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  PC_W  pc of the head entry.
- out_inst  output  INST_W  instruction of the head entry.
- out_misalign  output  1  head entry pc[1:0] != 0.
- count  output  clog2(DEPTH)+1  number of occupied entries (0..DEPTH).

Behaviour:
- Reset (rst=0, asynchronous): count=0, read and write pointers=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0, out_misalign=0. Storage contents are don't-care.
- Push: the queue pushes when in_valid && in_ready at a clock edge. The entry is written at wr_ptr and wr_ptr wraps modulo DEPTH. misalign = |in_pc[1:0] is stored alongside the entry.
- Pop: the queue pops when out_valid && out_ready at a clock edge. rd_ptr advances, wrapping modulo DEPTH.
- in_ready = (count != DEPTH) && !flush. It depends only on registered state and flush; there is no combinational path from out_ready.
- out_valid = (count != 0) && !flush.
- out_pc, out_inst and out_misalign are driven from the entry at rd_ptr. They are 0 whenever out_valid=0.
- Latency: a pair pushed at edge N is visible at the outputs after edge N, i.e. one-cycle latency. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Permitted whenever count is in 1..DEPTH-1; count is unchanged.
  - At count=DEPTH, push is blocked; a pop still occurs, and in_ready is 1 on the next cycle.
  - At count=0, pop is impossible; a push still occurs.
- Count update: +1 on push only, -1 on pop only.
- Flush (sampled at the edge):
  - No push and no pop occur.
  - Next state: count=0 and rd_ptr=wr_ptr=0.
  - Flush has priority over all other activity.
  - Flush at count=0 is harmless.
  - Flush held for several cycles keeps the queue empty and in_ready=0.
- Never overflow or underflow: count stays within 0..DEPTH under any input sequence.
- Fetch-side contract: in_pc/in_inst must stay stable while in_valid=1 and in_ready=0. The queue does not check this.
- Reset mid-operation discards everything, identically to power-on reset.

Decomposition:
- defines.v additions: `INST_BUS (31:0), `INST_Q_DEPTH (4). Reuse the existing `REG_BUS and `RESET_PC.
- One sub-module: inst_queue_ram, a DEPTH x (PC_W+INST_W+1) register array with write port and asynchronous read port. It has no reset on data.
- Pointer, count and handshake logic live in inst_queue.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> count=0, out_valid=0, in_ready=1, all outputs 0. Asserting rst=0 asynchronously mid-cycle with count=3 -> count=0 immediately, without waiting for an edge.
- Fill and drain in order: push pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C (inst 0x00000013, 0x00100093, 0x00200113, 0x00300193) with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is not accepted. Then out_ready=1 -> the four entries emerge in order, one per cycle; afterwards count=0, out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously from empty -> the first output appears one cycle after the first push, then one entry per cycle. count holds at 1 with no bubbles over 16 cycles.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3, in_ready=1 next cycle. On the following edge, push and pop together keep count=3.
- Flush: count=3, then flush=1 together with in_valid=1 and out_ready=1 -> no pop, no push; next cycle count=0, out_valid=0. Push 0x80000100 -> it appears at the outputs as the head entry.
- Misalign tag: push in_pc=0x80000002 -> out_misalign=1 with out_pc=0x80000002. Next push 0x80000004 -> out_misalign=0.
